// File: rtl/compute_seq_unit_if.sv
// compute_seq_unit_if
// Request/response bundle between the issue control and the nibble-serial
// compute unit.
//   start  : request strobe, carries op/a/b on the accepting edge
//   op     : 00 ADD, 01 SUB, 10 PADDSB, 11 RED
//   a, b   : 16-bit operands
//   busy   : unit is iterating over slices
//   done   : one-cycle pulse, result/ovfl valid
//   result : registered 16-bit result, held until the next completion
//   ovfl   : registered overflow/saturation flag qualifying result
//   err    : one-cycle pulse, a start arrived while busy and was dropped
// master = issue control side, slave = compute unit side.
interface compute_seq_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovfl;
  logic        err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, ovfl, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, ovfl, err
  );
endinterface

// File: rtl/compute_seq_unit.sv
// compute_seq_unit
// Multi-cycle execution unit for saturating ADD/SUB, nibble-wise saturating
// PADDSB and the byte reduction RED. One 4-bit adder slice is reused over four
// cycles (LSB slice first); RED uses a 10-bit accumulator over the four bytes.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : compute_seq_unit_if.slave (start/op/a/b in; busy/done/result/ovfl/err out)
module compute_seq_unit (
  input logic               clk,
  input logic               rst,
  compute_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_PADDSB = 2'b10;
  localparam logic [1:0] OP_RED    = 2'b11;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_cnt;
  logic [1:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_carry;
  logic [15:0] r_shift;
  logic        r_povf;
  logic [9:0]  r_acc;
  logic [15:0] r_result;
  logic        r_ovfl;
  logic        r_err;

  logic        w_accept;
  logic        w_last;
  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic [3:0]  w_b_eff;
  logic        w_cin;
  logic [4:0]  w_sum;
  logic        w_nib_ovf;
  logic [3:0]  w_nib_out;
  logic [15:0] w_shift_next;
  logic [7:0]  w_byte;
  logic [9:0]  w_acc_next;
  logic [15:0] w_fin_result;
  logic        w_fin_ovfl;

  // A new request is taken in IDLE and also in DONE (back-to-back issue).
  assign w_accept = bus.start && (r_state != S_EXEC);
  assign w_last   = (r_cnt == 2'd3);

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_EXEC;
      S_EXEC:  if (w_last)    w_next_state = S_DONE;
      S_DONE:  w_next_state = bus.start ? S_EXEC : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------- slice datapath ----------------
  assign w_a_nib = r_a[{r_cnt, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_cnt, 2'b00} +: 4];
  // SUB is a + ~b + 1; the +1 comes from the carry register preset at accept.
  assign w_b_eff = (r_op == OP_SUB) ? ~w_b_nib : w_b_nib;
  // PADDSB lanes are independent, so the ripple carry is ignored.
  assign w_cin   = (r_op == OP_PADDSB) ? 1'b0 : r_carry;
  assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_eff} + {4'b0000, w_cin};

  // Signed overflow of this slice. On the top slice this is also the word
  // overflow of ADD/SUB, since w_a_nib[3]/w_b_eff[3] are the operand signs.
  assign w_nib_ovf = (w_a_nib[3] == w_b_eff[3]) && (w_sum[3] != w_a_nib[3]);
  assign w_nib_out = ((r_op == OP_PADDSB) && w_nib_ovf)
                     ? (w_a_nib[3] ? 4'h8 : 4'h7) : w_sum[3:0];
  // New slice enters at the top; after four shifts slice 0 sits in [3:0].
  assign w_shift_next = {w_nib_out, r_shift[15:4]};

  // RED byte order: a[7:0], a[15:8], b[7:0], b[15:8].
  always_comb begin
    w_byte = r_a[7:0];
    case (r_cnt)
      2'd0: w_byte = r_a[7:0];
      2'd1: w_byte = r_a[15:8];
      2'd2: w_byte = r_b[7:0];
      2'd3: w_byte = r_b[15:8];
      default: w_byte = r_a[7:0];
    endcase
  end
  assign w_acc_next = r_acc + {{2{w_byte[7]}}, w_byte};

  // Final result selection, only used on the last slice.
  always_comb begin
    w_fin_result = w_shift_next;
    w_fin_ovfl   = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        if (w_nib_ovf) begin
          w_fin_result = r_a[15] ? 16'h8000 : 16'h7FFF;
          w_fin_ovfl   = 1'b1;
        end
      end
      OP_PADDSB: w_fin_ovfl = r_povf | w_nib_ovf;
      OP_RED:    w_fin_result = {{6{w_acc_next[9]}}, w_acc_next};
      default:   w_fin_ovfl = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 2'd0;
      r_op     <= OP_ADD;
      r_a      <= 16'h0000;
      r_b      <= 16'h0000;
      r_carry  <= 1'b0;
      r_shift  <= 16'h0000;
      r_povf   <= 1'b0;
      r_acc    <= 10'd0;
      r_result <= 16'h0000;
      r_ovfl   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // A start during EXEC is dropped and only flagged.
      r_err <= (r_state == S_EXEC) && bus.start;
      if (w_accept) begin
        r_op    <= bus.op;
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_cnt   <= 2'd0;
        r_carry <= (bus.op == OP_SUB);
        r_shift <= 16'h0000;
        r_povf  <= 1'b0;
        r_acc   <= 10'd0;
      end else if (r_state == S_EXEC) begin
        r_cnt   <= r_cnt + 2'd1;
        r_carry <= w_sum[4];
        r_shift <= w_shift_next;
        r_povf  <= r_povf | w_nib_ovf;
        r_acc   <= w_acc_next;
        if (w_last) begin
          r_result <= w_fin_result;
          r_ovfl   <= w_fin_ovfl;
        end
      end
    end
  end

  assign bus.busy   = (r_state == S_EXEC);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
  assign bus.ovfl   = r_ovfl;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_compute_seq_unit.sv
// tb_compute_seq_unit
// Self-checking bench for compute_seq_unit: a transaction-level reference
// (integer arithmetic with clamping, plus a cycle countdown) is compared with
// the DUT outputs on every falling edge; directed cases pin literal values.
module tb_compute_seq_unit;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  compute_seq_unit_if bus ();

  compute_seq_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {ovfl, result} from the arithmetic meaning of each op.
  function automatic logic [16:0] ref_op(input logic [1:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    int          s;
    int          na;
    int          nb;
    logic [15:0] r;
    logic        ov;
    r  = 16'h0000;
    ov = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        na = int'($signed(a));
        nb = int'($signed(b));
        s  = (op == 2'b00) ? na + nb : na - nb;
        if (s > 32767)       begin r = 16'h7FFF; ov = 1'b1; end
        else if (s < -32768) begin r = 16'h8000; ov = 1'b1; end
        else                 r = 16'(s);
      end
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          na = int'($signed(a[i*4 +: 4]));
          nb = int'($signed(b[i*4 +: 4]));
          s  = na + nb;
          if (s > 7)       begin s = 7;  ov = 1'b1; end
          else if (s < -8) begin s = -8; ov = 1'b1; end
          r[i*4 +: 4] = 4'(s);
        end
      end
      default: begin
        s = int'($signed(a[7:0])) + int'($signed(a[15:8]))
          + int'($signed(b[7:0])) + int'($signed(b[15:8]));
        r = 16'(s);
      end
    endcase
    return {ov, r};
  endfunction

  // Cycle-level expectation: an accepted request completes 4 edges later.
  int          m_left;
  logic        m_done;
  logic        m_err;
  logic [15:0] m_result;
  logic        m_ovfl;
  logic [16:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   = 0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_result = 16'h0000;
      m_ovfl   = 1'b0;
      m_pend   = 17'h0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_left > 0) begin
        m_err  = bus.start;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_done   = 1'b1;
          m_result = m_pend[15:0];
          m_ovfl   = m_pend[16];
        end
      end else if (bus.start) begin
        m_pend = ref_op(bus.op, bus.a, bus.b);
        m_left = 4;
      end
    end
  end

  always @(negedge clk) begin
    check("busy",   32'(bus.busy),   32'(m_left > 0));
    check("done",   32'(bus.done),   32'(m_done));
    check("err",    32'(bus.err),    32'(m_err));
    check("result", 32'(bus.result), 32'(m_result));
    check("ovfl",   32'(bus.ovfl),   32'(m_ovfl));
    check("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
  end

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.done && cycles < 12);
  endtask

  // Issue one op, wait for done, check latency and literal result.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_r, input logic exp_o);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
    wait_done(cyc);
    check({name, " latency"}, 32'(cyc), 32'd4);
    check({name, " result"}, 32'(bus.result), 32'(exp_r));
    check({name, " ovfl"},   32'(bus.ovfl),   32'(exp_o));
  endtask

  initial begin
    int cyc;
    int n_done;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 16'h0000; bus.b = 16'h0000;
    rst = 1'b1;
    #1;
    check("reset result", 32'(bus.result), 32'h0);
    check("reset busy",   32'(bus.busy),   32'h0);
    check("reset done",   32'(bus.done),   32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Pin the reference model with hand-computed values.
    check("model add sat",  32'(ref_op(2'b00, 16'h7FFF, 16'h0001)), 32'h17FFF);
    check("model sub sat",  32'(ref_op(2'b01, 16'h0000, 16'h8000)), 32'h17FFF);
    check("model paddsb",   32'(ref_op(2'b10, 16'h7181, 16'h1F8F)), 32'h17080);
    check("model red neg",  32'(ref_op(2'b11, 16'h8080, 16'h8080)), 32'h0FE00);

    // Directed cases.
    run_op("ADD sat",     2'b00, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1);
    run_op("ADD 3+4",     2'b00, 16'h0003, 16'h0004, 16'h0007, 1'b0);
    run_op("SUB sat",     2'b01, 16'h8000, 16'h0001, 16'h8000, 1'b1);
    run_op("SUB 5-3",     2'b01, 16'h0005, 16'h0003, 16'h0002, 1'b0);
    run_op("SUB 0-8000",  2'b01, 16'h0000, 16'h8000, 16'h7FFF, 1'b1);
    run_op("PADDSB sat",  2'b10, 16'h7181, 16'h1F8F, 16'h7080, 1'b1);
    run_op("PADDSB",      2'b10, 16'h1234, 16'h1111, 16'h2345, 1'b0);
    run_op("RED 1111",    2'b11, 16'h1111, 16'h1111, 16'h0044, 1'b0);
    run_op("RED 8080",    2'b11, 16'h8080, 16'h8080, 16'hFE00, 1'b0);
    run_op("RED 7F7F",    2'b11, 16'h7F7F, 16'h7F7F, 16'h01FC, 1'b0);

    // Back-to-back: start raised while in DONE.
    run_op("B2B first",   2'b01, 16'h0005, 16'h0003, 16'h0002, 1'b0);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h0001; bus.b = 16'h0001;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    check("B2B latency", 32'(cyc), 32'd4);
    check("B2B result",  32'(bus.result), 32'h0002);

    // start pulsed mid-EXEC: err pulse, request dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h0003; bus.b = 16'h0004;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 16'hFFFF; bus.b = 16'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    check("err pulse", 32'(bus.err), 32'd1);
    @(negedge clk);
    check("err single", 32'(bus.err), 32'd0);
    wait_done(cyc);
    check("err first result", 32'(bus.result), 32'h0007);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("err no extra done", 32'(n_done), 32'd0);

    // Asynchronous reset while cnt==2.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h7FFF; bus.b = 16'h7FFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst busy",   32'(bus.busy),   32'd0);
    check("rst done",   32'(bus.done),   32'd0);
    check("rst err",    32'(bus.err),    32'd0);
    check("rst ovfl",   32'(bus.ovfl),   32'd0);
    check("rst result", 32'(bus.result), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("rst no done", 32'(n_done), 32'd0);
    run_op("ADD after rst", 2'b00, 16'h0010, 16'h0020, 16'h0030, 1'b0);

    // Random traffic, including starts during EXEC and in DONE.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op    = 2'($urandom);
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/compute_seq_unit.md
# compute_seq_unit

Multi-cycle, nibble-serial execution unit for the saturating compute instructions: ADD, SUB, PADDSB and RED. It uses one 4-bit adder slice, or a 10-bit accumulator for RED, and iterates over four cycles. This trades latency for area compared with the single-cycle adder datapath. It sits beside the ALU in the execute stage and is driven with a start/done handshake by the issue control.

## Interface
- No parameters; data width fixed at 16, slice width 4.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  00 ADD, 01 SUB, 10 PADDSB, 11 RED; latched with start.
- a  in  16  operand A (rs); latched with start.
- b  in  16  operand B (rt); latched with start.
- busy  out  1  high while in EXEC.
- done  out  1  one-cycle pulse; result valid.
- result  out  16  registered result; held until the next DONE.
- ovfl  out  1  registered overflow/saturation flag; qualifies result.
- err  out  1  one-cycle pulse when start is seen during EXEC (request dropped).

## Operation
- States: IDLE, EXEC, DONE. Counter cnt is 2 bits.
- IDLE: if start, latch op/a/b, set cnt=0 and carry, then go to EXEC.
  - Carry is set to 1 for SUB, 0 otherwise.
- EXEC: each cycle processes slice cnt, LSB slice first. At cnt==3, load result/ovfl and go to DONE; otherwise cnt++.
- DONE: done=1. If start, latch the new request and go to EXEC (back-to-back). Otherwise go to IDLE.
- ADD/SUB:
  - 16-bit ripple across slices via the carry register; SUB uses ~b with carry-in 1.
  - Raw sum is assembled in a shift register.
  - Overflow: operand signs (a[15], effective b[15]) agree and the raw sum sign differs.
  - On overflow, result = 7FFF if a[15]==0, else 8000; ovfl=1.
  - No overflow: result = raw sum, ovfl=0.
- PADDSB:
  - Each nibble is an independent signed add with carry-in 0; no carry between slices.
  - Each nibble saturates independently: positive overflow -> 7, negative overflow -> 8.
  - ovfl = OR of the four nibble overflows.
- RED:
  - 10-bit signed accumulator, cleared at start.
  - cnt 0..3 add sign-extended bytes a[7:0], a[15:8], b[7:0], b[15:8], in that order.
  - result = accumulator sign-extended to 16 bits (range -512..508, never saturates); ovfl=0.
- err: asserted for one cycle when start=1 in EXEC. State, operands and counter are unaffected.

## Timing
- Reset (async, any state):
  - state=IDLE, cnt=0.
  - busy=0, done=0, err=0, ovfl=0, result=0000.
  - Internal operand, carry, shift and accumulator registers are cleared.
- Reset asserted mid-EXEC aborts the operation; no done is issued.
- Latency: start sampled at edge N -> busy=1 after N.
  - Slices are processed at edges N+1..N+4.
  - result/ovfl/done update at edge N+4; done is high for exactly one cycle, busy=0 in the same cycle.
- Throughput: one op per 4 cycles when start is held high in DONE.
- Operand inputs are don't-care except at the accepting edge.
- result/ovfl are stable outside the DONE-loading edge. They are not cleared by IDLE.
- busy and done are never high together.

## Test plan
- ADD a=7FFF, b=0001 -> done exactly 4 cycles after start; result=7FFF, ovfl=1.
  - ADD 0003+0004 -> 0007, ovfl=0.
- SUB a=8000, b=0001 -> result=8000, ovfl=1.
  - SUB 0005-0003 -> 0002, ovfl=0.
  - SUB 0000-8000 -> 7FFF, ovfl=1.
- PADDSB a=7181, b=1F8F -> result=7080, ovfl=1.
  - PADDSB 1234+1111 -> 2345, ovfl=0.
- RED a=1111, b=1111 -> result=0044.
  - RED a=8080, b=8080 -> FE00.
  - RED a=7F7F, b=7F7F -> 01FC; ovfl=0 in all cases.
- Handshake:
  - start held high across DONE -> second op (ADD 0001+0001 -> 0002) completes 4 cycles after the first done.
  - start pulsed mid-EXEC -> err pulse one cycle, first op result unchanged, no extra done.
- Reset asserted during EXEC cnt=2 -> all outputs 0 immediately (asynchronous), no done.
  - After release, ADD 0010+0020 -> 0030 with normal latency.
